// File: rtl/sdram_pkg.sv
// sdram_pkg: definitions shared by the SDRAM controller engines and the bus
// arbiter.
//   - CMD_* : {cs_n, ras_n, cas_n, we_n} command encodings
//   - state_t : arbiter state, which also names the engine that owns the bus
package sdram_pkg;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;

  typedef enum logic [2:0] {
    INIT_WAIT,
    ARBIT,
    AREF,
    WRITE,
    READ
  } state_t;

endpackage

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: grants the SDRAM pins to one engine at a time.
//   The init engine owns the bus until init_end. After that, requests from
//   the refresh, write and read engines are served with fixed priority
//   refresh > write > read, without preemption, and with at least one idle
//   (NOP) cycle between two grants. A grant that is held for TIMEOUT cycles
//   is withdrawn and timeout_err is latched until reset.
// Ports:
//   sys_clk, sys_rst          clock, asynchronous active-low reset
//   init_*                    init engine bus and completion level
//   aref_* / wr_* / rd_*      engine request, end pulse, bus and grant
//   wr_dq_oe, wr_dq           write data and its output enable
//   rd_dq                     DQ pins as seen by the read engine
//   timeout_err               sticky grant-timeout flag
//   sdram_*                   SDRAM pad signals
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int ADDR_W  = 13,
  parameter int BA_W    = 2,
  parameter int DQ_W    = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [BA_W-1:0]   init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [BA_W-1:0]   aref_ba,
  input  logic [ADDR_W-1:0] aref_addr,
  output logic              aref_en,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_dq_oe,
  input  logic [DQ_W-1:0]   wr_dq,
  output logic              wr_en,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [BA_W-1:0]   rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  output logic [DQ_W-1:0]   rd_dq,
  output logic              timeout_err,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  inout  wire  [DQ_W-1:0]   sdram_dq
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Value of the counter during the last cycle a grant may be held; the
  // edge that ends that cycle is the one where the counter reaches TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             aref_en_reg, wr_en_reg, rd_en_reg;
  logic             timeout_err_reg;
  logic             hit_timeout;
  logic             owner_end;

  // End pulse of whichever engine currently owns the bus; pulses from
  // engines without a grant never reach the state machine.
  always_comb begin
    owner_end = 1'b0;
    case (state_reg)
      AREF:    owner_end = aref_end;
      WRITE:   owner_end = wr_end;
      READ:    owner_end = rd_end;
      default: owner_end = 1'b0;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = '0;
    hit_timeout = 1'b0;
    case (state_reg)
      INIT_WAIT: begin
        if (init_end) state_next = ARBIT;
      end
      ARBIT: begin
        if (aref_req)    state_next = AREF;
        else if (wr_req) state_next = WRITE;
        else if (rd_req) state_next = READ;
      end
      AREF, WRITE, READ: begin
        cnt_next    = cnt_reg + CNT_W'(1);
        hit_timeout = (cnt_reg == CNT_LAST);
        if (owner_end || hit_timeout) state_next = ARBIT;
      end
      default: state_next = INIT_WAIT;
    endcase
  end

  // Grants are decoded from the next state so they line up exactly with the
  // state register while still coming straight from flops.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_reg       <= INIT_WAIT;
      cnt_reg         <= '0;
      aref_en_reg     <= 1'b0;
      wr_en_reg       <= 1'b0;
      rd_en_reg       <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      aref_en_reg <= (state_next == AREF);
      wr_en_reg   <= (state_next == WRITE);
      rd_en_reg   <= (state_next == READ);
      if (hit_timeout) timeout_err_reg <= 1'b1;
    end
  end

  assign aref_en     = aref_en_reg;
  assign wr_en       = wr_en_reg;
  assign rd_en       = rd_en_reg;
  assign timeout_err = timeout_err_reg;
  assign sdram_cke   = 1'b1;

  // Pin mux straight off the state register, no added pipeline stage.
  logic [3:0]        sel_cmd;
  logic [BA_W-1:0]   sel_ba;
  logic [ADDR_W-1:0] sel_addr;

  always_comb begin
    sel_cmd  = CMD_NOP;
    sel_ba   = '1;
    sel_addr = '1;
    case (state_reg)
      INIT_WAIT: begin
        sel_cmd  = init_cmd;
        sel_ba   = init_ba;
        sel_addr = init_addr;
      end
      AREF: begin
        sel_cmd  = aref_cmd;
        sel_ba   = aref_ba;
        sel_addr = aref_addr;
      end
      WRITE: begin
        sel_cmd  = wr_cmd;
        sel_ba   = wr_ba;
        sel_addr = wr_addr;
      end
      READ: begin
        sel_cmd  = rd_cmd;
        sel_ba   = rd_ba;
        sel_addr = rd_addr;
      end
      default: begin
        sel_cmd  = CMD_NOP;
        sel_ba   = '1;
        sel_addr = '1;
      end
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = sel_cmd;
  assign sdram_ba   = sel_ba;
  assign sdram_addr = sel_addr;

  // DQ is driven only by a granted writer that asks for it; reset forces the
  // state back to INIT_WAIT and so releases the pins at once.
  logic dq_oe;
  assign dq_oe = (state_reg == WRITE) && wr_dq_oe;

  genvar gi;
  generate
    for (gi = 0; gi < DQ_W; gi++) begin : g_dq
      assign sdram_dq[gi] = dq_oe ? wr_dq[gi] : 1'bz;
    end
  endgenerate

  assign rd_dq = sdram_dq;

endmodule
